// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard controller.
// Builds the per-stage hold mask from stall sources and sequences
// multi-cycle ops hosted in MC_STAGE. It also registers the exception
// flush pulse together with the redirect PC.
module pipe_ctrl #(
  parameter int          STAGES   = 6,
  parameter int          MC_STAGE = 3,
  parameter int          CNT_W    = 6,
  parameter int          PC_W     = 32,
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stallreq,
  input  logic              mc_start,
  input  logic [CNT_W-1:0]  mc_len,
  input  logic              excp_req,
  input  logic [PC_W-1:0]   excp_pc,
  output logic [STAGES-1:0] stall,
  output logic              mc_done,
  output logic              flush,
  output logic [PC_W-1:0]   new_pc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               mc_req;
  logic               start_ok;
  logic [STAGES-1:0]  src;

  // A new op may be accepted from IDLE, or from DONE for back-to-back issue.
  assign start_ok = (state_q == IDLE) || (state_q == DONE);

  // FSM state register; an exception aborts any in-flight op.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else if (excp_req) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next-state: length N>=2 goes through BUSY for N-1 cycles, N<=1 goes straight to DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (mc_start) begin
          if (mc_len[CNT_W-1:1] != '0) begin
            cnt_d   = mc_len - CNT_W'(1);
            state_d = BUSY;
          end else begin
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM outputs: completion pulse and the internal hold request at MC_STAGE.
  always_comb begin
    mc_done = (state_q == DONE);
    mc_req  = (state_q == BUSY) || (start_ok && mc_start && (mc_len != '0));
  end

  // Stall mask: freeze every stage at or below the highest active source.
  always_comb begin
    logic acc;
    src           = stallreq;
    src[MC_STAGE] = stallreq[MC_STAGE] | mc_req;
    stall         = '0;
    acc           = 1'b0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      acc      = acc | src[i];
      stall[i] = acc;
    end
    // Reset and a flush in progress both release every stage.
    if (!rst || flush) begin
      stall = '0;
    end
  end

  // Flush pulse and redirect target; new_pc holds its value between flushes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      flush  <= 1'b0;
      new_pc <= PC_W'(RESET_PC);
    end else begin
      flush <= excp_req;
      if (excp_req) begin
        new_pc <= excp_pc;
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl (STAGES=6, MC_STAGE=3).
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic [5:0]  stallreq;
  logic        mc_start;
  logic [5:0]  mc_len;
  logic        excp_req;
  logic [31:0] excp_pc;
  logic [5:0]  stall;
  logic        mc_done;
  logic        flush;
  logic [31:0] new_pc;

  int total;
  int passed;

  pipe_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .stallreq (stallreq),
    .mc_start (mc_start),
    .mc_len   (mc_len),
    .excp_req (excp_req),
    .excp_pc  (excp_pc),
    .stall    (stall),
    .mc_done  (mc_done),
    .flush    (flush),
    .new_pc   (new_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst      = 1'b0;
    stallreq = 6'b111111;
    excp_req = 1'b1;
    excp_pc  = 32'h1111_2222;
    mc_start = 1'b1;
    mc_len   = 6'd4;
    next_cycle();
    next_cycle();
    #1;
    total++; if (stall !== 6'b0) $display("FAIL reset_stall got=%b exp=%b", stall, 6'b0); else passed++;
    total++; if (flush !== 1'b0) $display("FAIL reset_flush got=%b exp=0", flush); else passed++;
    total++; if (mc_done !== 1'b0) $display("FAIL reset_mc_done got=%b exp=0", mc_done); else passed++;
    total++; if (new_pc !== 32'hBFC0_0000) $display("FAIL reset_new_pc got=%h exp=%h", new_pc, 32'hBFC0_0000); else passed++;
    rst      = 1'b1;
    stallreq = '0;
    excp_req = 1'b0;
    mc_start = 1'b0;
    mc_len   = '0;
    next_cycle();
  endtask

  task automatic test_decode();
    logic [5:0] req [5];
    logic [5:0] exp [5];
    req[0] = 6'b000100; exp[0] = 6'b000111;
    req[1] = 6'b001000; exp[1] = 6'b001111;
    req[2] = 6'b010100; exp[2] = 6'b011111;
    req[3] = 6'b000000; exp[3] = 6'b000000;
    req[4] = 6'b100001; exp[4] = 6'b111111;
    for (int i = 0; i < 5; i++) begin
      stallreq = req[i];
      #1;
      total++;
      if (stall !== exp[i]) $display("FAIL decode_%0d req=%b got=%b exp=%b", i, req[i], stall, exp[i]);
      else passed++;
    end
    stallreq = '0;
    next_cycle();
  endtask

  // Single ops of length 3, 0 and 1: per-cycle stall and done masks.
  task automatic test_multicycle();
    logic [5:0] lens [3];
    logic [7:0] s_exp [3];
    logic [7:0] d_exp [3];
    lens[0] = 6'd3; s_exp[0] = 8'b0000_0111; d_exp[0] = 8'b0000_1000;
    lens[1] = 6'd0; s_exp[1] = 8'b0000_0000; d_exp[1] = 8'b0000_0010;
    lens[2] = 6'd1; s_exp[2] = 8'b0000_0001; d_exp[2] = 8'b0000_0010;
    for (int t = 0; t < 3; t++) begin
      for (int c = 0; c < 8; c++) begin
        mc_start = (c == 0);
        mc_len   = (c == 0) ? lens[t] : 6'd0;
        #1;
        total++;
        if (stall !== (s_exp[t][c] ? 6'b001111 : 6'b000000))
          $display("FAIL mc_len%0d_stall c=%0d got=%b exp=%b", lens[t], c, stall, s_exp[t][c] ? 6'b001111 : 6'b000000);
        else passed++;
        total++;
        if (mc_done !== d_exp[t][c])
          $display("FAIL mc_len%0d_done c=%0d got=%b exp=%b", lens[t], c, mc_done, d_exp[t][c]);
        else passed++;
        next_cycle();
      end
    end
    mc_start = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] s_exp;
    logic [7:0] d_exp;
    s_exp = 8'b0000_1111;
    d_exp = 8'b0001_0100;
    for (int c = 0; c < 8; c++) begin
      mc_start = (c == 0) || (c == 2);
      mc_len   = mc_start ? 6'd2 : 6'd0;
      #1;
      total++;
      if (stall !== (s_exp[c] ? 6'b001111 : 6'b000000))
        $display("FAIL b2b_stall c=%0d got=%b exp=%b", c, stall, s_exp[c] ? 6'b001111 : 6'b000000);
      else passed++;
      total++;
      if (mc_done !== d_exp[c]) $display("FAIL b2b_done c=%0d got=%b exp=%b", c, mc_done, d_exp[c]);
      else passed++;
      next_cycle();
    end
    mc_start = 1'b0;
    mc_len   = '0;
  endtask

  // stallreq above MC_STAGE widens the mask, below it is subsumed; counter keeps running.
  task automatic test_widen();
    logic [5:0] req [6];
    logic [5:0] exp [6];
    logic [5:0] d_exp;
    req[0] = 6'b000000; exp[0] = 6'b001111;
    req[1] = 6'b010000; exp[1] = 6'b011111;
    req[2] = 6'b000010; exp[2] = 6'b001111;
    req[3] = 6'b100000; exp[3] = 6'b111111;
    req[4] = 6'b000000; exp[4] = 6'b000000;
    req[5] = 6'b000010; exp[5] = 6'b000011;
    d_exp = 6'b010000;
    for (int c = 0; c < 6; c++) begin
      mc_start = (c == 0);
      mc_len   = (c == 0) ? 6'd4 : 6'd0;
      stallreq = req[c];
      #1;
      total++;
      if (stall !== exp[c]) $display("FAIL widen_stall c=%0d got=%b exp=%b", c, stall, exp[c]);
      else passed++;
      total++;
      if (mc_done !== d_exp[c]) $display("FAIL widen_done c=%0d got=%b exp=%b", c, mc_done, d_exp[c]);
      else passed++;
      next_cycle();
    end
    mc_start = 1'b0;
    stallreq = '0;
    next_cycle();
  endtask

  task automatic test_flush_abort();
    for (int c = 0; c < 14; c++) begin
      mc_start = (c == 0);
      mc_len   = (c == 0) ? 6'd10 : 6'd0;
      excp_req = (c == 4);
      excp_pc  = (c == 4) ? 32'h8000_0180 : 32'hDEAD_BEEF;
      #1;
      total++;
      if (stall !== ((c <= 4) ? 6'b001111 : 6'b000000))
        $display("FAIL flush_stall c=%0d got=%b exp=%b", c, stall, (c <= 4) ? 6'b001111 : 6'b000000);
      else passed++;
      total++;
      if (flush !== (c == 5)) $display("FAIL flush_pulse c=%0d got=%b exp=%b", c, flush, (c == 5));
      else passed++;
      total++;
      if (mc_done !== 1'b0) $display("FAIL flush_no_done c=%0d got=%b exp=0", c, mc_done);
      else passed++;
      if (c >= 5) begin
        total++;
        if (new_pc !== 32'h8000_0180) $display("FAIL flush_new_pc c=%0d got=%h exp=%h", c, new_pc, 32'h8000_0180);
        else passed++;
      end
      next_cycle();
    end
    excp_req = 1'b0;
  endtask

  task automatic test_priority();
    for (int c = 0; c < 8; c++) begin
      excp_req = (c == 0);
      excp_pc  = 32'h1234_5678;
      mc_start = (c == 0);
      mc_len   = (c == 0) ? 6'd5 : 6'd0;
      #1;
      if (c >= 1) begin
        total++;
        if (stall !== 6'b0) $display("FAIL prio_stall c=%0d got=%b exp=%b", c, stall, 6'b0);
        else passed++;
        total++;
        if (flush !== (c == 1)) $display("FAIL prio_flush c=%0d got=%b exp=%b", c, flush, (c == 1));
        else passed++;
        total++;
        if (mc_done !== 1'b0) $display("FAIL prio_done c=%0d got=%b exp=0", c, mc_done);
        else passed++;
      end
      if (c == 1) begin
        total++;
        if (new_pc !== 32'h1234_5678) $display("FAIL prio_new_pc got=%h exp=%h", new_pc, 32'h1234_5678);
        else passed++;
      end
      next_cycle();
    end
    excp_req = 1'b0;
    mc_start = 1'b0;
  endtask

  // Reset asserted while BUSY clears the op and the mask in that same cycle.
  task automatic test_reset_mid_op();
    for (int c = 0; c < 8; c++) begin
      mc_start = (c == 0);
      mc_len   = (c == 0) ? 6'd5 : 6'd0;
      rst      = (c != 2);
      #1;
      total++;
      if (stall !== ((c <= 1) ? 6'b001111 : 6'b000000))
        $display("FAIL rstmid_stall c=%0d got=%b exp=%b", c, stall, (c <= 1) ? 6'b001111 : 6'b000000);
      else passed++;
      total++;
      if (mc_done !== 1'b0) $display("FAIL rstmid_done c=%0d got=%b exp=0", c, mc_done);
      else passed++;
      if (c == 3) begin
        total++;
        if (new_pc !== 32'hBFC0_0000) $display("FAIL rstmid_new_pc got=%h exp=%h", new_pc, 32'hBFC0_0000);
        else passed++;
      end
      next_cycle();
    end
    rst      = 1'b1;
    mc_start = 1'b0;
  endtask

  initial begin
    total    = 0;
    passed   = 0;
    rst      = 1'b0;
    stallreq = '0;
    mc_start = 1'b0;
    mc_len   = '0;
    excp_req = 1'b0;
    excp_pc  = '0;
    next_cycle();
    test_reset();
    test_decode();
    test_multicycle();
    test_back_to_back();
    test_widen();
    test_flush_abort();
    test_priority();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
